mc_control_fsm: RTL
===================

Name: mc_control_fsm

Overview:
Multi-cycle MIPS main control FSM; the driving end of the ALU's operation/zero interface.
- Sequences FETCH/DECODE/EXEC/MEM/WB per instruction.
- Issues the 4-bit ALU operation code and select/enable strobes to the datapath.
- Consumes the ALU zero flag to resolve beq, and a memory ready handshake to stretch memory states.
- Sits between the instruction register and the multi-cycle datapath.

Parameters:
- STATE_W, 4, width of the state register and of the state debug port.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  IR[31:26]; valid from DECODE onward.
- funct  in  6  IR[5:0]; valid from DECODE onward.
- zero  in  1  ALU equality flag.
- mem_ready  in  1  memory access complete this cycle.
- operation  out  4  ALU op: 0000 and, 0001 or, 0010 add, 0110 sub, 0111 slt.
- alu_src_a  out  1  0=PC, 1=reg A.
- alu_src_b  out  2  0=reg B, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2.
- i_or_d  out  1  memory address select: 0=PC, 1=ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  load IR.
- reg_dst  out  1  0=rt, 1=rd.
- mem_to_reg  out  1  0=ALUOut, 1=MDR.
- reg_write  out  1  register file write enable.
- pc_source  out  2  0=ALU, 1=ALUOut, 2=jump target.
- pc_write  out  1  PC load, unconditional or branch-resolved.
- illegal_instr  out  1  sticky unsupported-opcode flag.
- state  out  STATE_W  current state, for debug.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-low, on rst_n. Asserting rst_n=0 at any time forces state=FETCH immediately and clears illegal_instr. An in-flight instruction is abandoned.
- Output style: Moore outputs decoded from state, except the mem_ready-gated strobes and the beq pc_write. In every state, any output not listed below is 0.
- Reset values of outputs: the FETCH decode, with mem_ready=0 during reset. operation=0010, alu_src_b=1, mem_read=1, state=0. All write enables are 0.
- State encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, TRAP 10, I_EXEC 11, I_WB 12.
- FETCH: i_or_d=0, mem_read=1, alu_src_a=0, alu_src_b=1, operation=0010, pc_source=0.
  - ir_write=mem_ready and pc_write=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=3, operation=0010 (branch target precompute).
  - Next state by opcode: 000000 to R_EXEC; 100011 or 101011 to MEM_ADDR; 000100 to BRANCH; 000010 to JUMP.
  - Any other opcode goes to TRAP.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, operation=0010. Goes to MEM_RD if opcode=lw, else MEM_WR.
- MEM_RD: i_or_d=1, mem_read=1. Holds until mem_ready=1, then MEM_WB.
- MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1. Then FETCH.
- MEM_WR: i_or_d=1, mem_write=1. Holds until mem_ready=1, then FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=0, operation from funct. Then R_WB.
  - funct map: 100000 to 0010, 100010 to 0110, 100100 to 0000, 100101 to 0001, 101010 to 0111.
  - Any other funct drives 0010 and sets illegal_instr. The instruction still completes.
- R_WB: reg_dst=1, mem_to_reg=0, reg_write=1. Then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, operation=0110, pc_source=1, pc_write=zero (same cycle). Then FETCH.
- JUMP: pc_source=2, pc_write=1. Then FETCH.
- TRAP: illegal_instr=1. Stays in TRAP until reset; no enables asserted.
- Latency with mem_ready tied high: beq and j take 3 cycles, R-type and sw take 4, lw takes 5.
- Memory handshake: each cycle of mem_ready=0 adds one cycle in FETCH, MEM_RD or MEM_WR.
- mem_ready is ignored in all other states.
- Unused state codes (13-15) go to FETCH.

Optional Feature:
- Macro: MC_CTRL_ADDI_EN.
- When defined: opcode 001000 (addi) goes DECODE to I_EXEC to I_WB to FETCH.
  - I_EXEC: alu_src_a=1, alu_src_b=2, operation=0010.
  - I_WB: reg_dst=0, mem_to_reg=0, reg_write=1.
  - addi takes 4 cycles.
- When undefined: 001000 goes to TRAP. The I_EXEC/I_WB logic is absent, and their state codes take the unused-code path.

Test Plan:
- R-type sub: opcode=000000, funct=100010, mem_ready=1 from FETCH.
  - Required: states 0,1,6,7,0; operation=0110 in R_EXEC; reg_write=1 and reg_dst=1 in R_WB only.
- lw with 2 wait cycles: opcode=100011, mem_ready low for 2 cycles in MEM_RD.
  - Required: MEM_RD held 3 cycles; reg_write=1 and mem_to_reg=1 for exactly one cycle; 7 cycles total.
- beq taken and not taken: opcode=000100 with zero=1, then repeated with zero=0.
  - Required: pc_write=1 with pc_source=1 in BRANCH for zero=1; pc_write=0 for zero=0; FETCH next in both cases.
- Illegal opcode then reset: opcode=111111.
  - Required: state=10 and illegal_instr=1, held for 20 cycles.
  - Pulsing rst_n=0 mid-cycle: state=0 and illegal_instr=0 immediately, without waiting for a clock edge.
- Fetch stall: mem_ready=0 for 5 cycles after reset.
  - Required: ir_write=0 and pc_write=0 throughout; both equal 1 in the cycle mem_ready=1; DECODE next.
- addi: opcode=001000.
  - With MC_CTRL_ADDI_EN defined: states 0,1,11,12,0 with alu_src_b=2 in I_EXEC.
  - Without the macro: TRAP.

Source files
------------

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback
// and drives ALU op plus datapath strobes. Define MC_CTRL_ADDI_EN to add addi support.
module mc_control_fsm #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic [3:0]         operation,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic [1:0]         pc_source,
    output logic               pc_write,
    output logic               illegal_instr,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = STATE_W'(0),
        S_DECODE   = STATE_W'(1),
        S_MEM_ADDR = STATE_W'(2),
        S_MEM_RD   = STATE_W'(3),
        S_MEM_WB   = STATE_W'(4),
        S_MEM_WR   = STATE_W'(5),
        S_R_EXEC   = STATE_W'(6),
        S_R_WB     = STATE_W'(7),
        S_BRANCH   = STATE_W'(8),
        S_JUMP     = STATE_W'(9),
        S_TRAP     = STATE_W'(10),
        S_I_EXEC   = STATE_W'(11),
        S_I_WB     = STATE_W'(12)
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_CTRL_ADDI_EN
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    state_t state_q, state_d;
    logic   illegal_q;
    logic   set_illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_q | set_illegal;
        end
    end

    // Strobes are Moore except FETCH's mem_ready-gated loads and BRANCH's zero-gated pc_write.
    always_comb begin
        state_d     = state_q;
        set_illegal = 1'b0;
        operation   = 4'b0000;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'd0;
        i_or_d      = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        pc_source   = 2'd0;
        pc_write    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                operation = ALU_ADD;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'd3;
                operation = ALU_ADD;
                case (opcode)
                    OP_RTYPE:     state_d = S_R_EXEC;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
`ifdef MC_CTRL_ADDI_EN
                    OP_ADDI:      state_d = S_I_EXEC;
`endif
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                operation = ALU_ADD;
                state_d   = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                i_or_d   = 1'b1;
                mem_read = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                i_or_d    = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                state_d   = S_R_WB;
                case (funct)
                    6'b100000: operation = ALU_ADD;
                    6'b100010: operation = ALU_SUB;
                    6'b100100: operation = ALU_AND;
                    6'b100101: operation = ALU_OR;
                    6'b101010: operation = ALU_SLT;
                    default: begin
                        operation   = ALU_ADD;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            S_R_WB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                operation = ALU_SUB;
                pc_source = 2'd1;
                pc_write  = zero;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_source = 2'd2;
                pc_write  = 1'b1;
                state_d   = S_FETCH;
            end
            S_TRAP: begin
                set_illegal = 1'b1;
            end
`ifdef MC_CTRL_ADDI_EN
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                operation = ALU_ADD;
                state_d   = S_I_WB;
            end
            S_I_WB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
`endif
            default: state_d = S_FETCH;
        endcase
    end

    // Flag shows in the offending cycle itself, then sticks until reset.
    assign illegal_instr = illegal_q | set_illegal;
    assign state         = state_q;

endmodule
